// File: rtl/mips_pkg.sv
// Shared types and widths for the MIPS pipeline slice: memory-stage FSM states
// and the architectural word/register-address widths.
package mips_pkg;

    localparam int WORD_W = 32;
    localparam int REG_AW = 5;
    localparam logic [REG_AW-1:0] REG_ZERO = 5'd0;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        RESP = 2'd2
    } memState_t;

endpackage

// File: rtl/mem_align_chk.sv
// Word-alignment check for load/store effective addresses.
// Active only when MEM_ALIGN_CHECK_EN is defined; otherwise the flag is constant 0.
module mem_align_chk
    import mips_pkg::*;
(
    input  logic [1:0] addrLow,
    input  logic       memOp,
    output logic       misaligned
);

`ifdef MEM_ALIGN_CHECK_EN
    assign misaligned = memOp && (addrLow != 2'b00);
`else
    logic unusedInputs;
    assign unusedInputs = &{1'b0, addrLow, memOp};
    assign misaligned   = 1'b0;
`endif

endmodule

// File: rtl/mem_stage.sv
// Load/store memory stage: req/ack word transaction on the data bus, upstream stall
// and registered register-file writeback. Optional macro: MEM_ALIGN_CHECK_EN.
module mem_stage
    import mips_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              Read,
    input  logic              Write,
    input  logic [WORD_W-1:0] ALUResult,
    input  logic [REG_AW-1:0] ALUResultRegAddr,
    input  logic [WORD_W-1:0] RtData,
    output logic              mem_req,
    output logic              mem_we,
    output logic [WORD_W-1:0] mem_addr,
    output logic [WORD_W-1:0] mem_wdata,
    input  logic              mem_ack,
    input  logic [WORD_W-1:0] mem_rdata,
    output logic              stall,
    output logic              wb_valid,
    output logic [REG_AW-1:0] wb_addr,
    output logic [WORD_W-1:0] wb_data,
    output logic              excp
);

    memState_t         state;
    memState_t         stateNext;
    logic              memOp;
    logic              misaligned;
    logic              launch;
    logic [REG_AW-1:0] destReg;

    assign memOp  = Read | Write;
    assign launch = (state == IDLE) && memOp && !misaligned;

    mem_align_chk uAlignChk (
        .addrLow    (ALUResult[1:0]),
        .memOp      (memOp),
        .misaligned (misaligned)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= stateNext;
    end

    always_comb begin
        stateNext = state;
        case (state)
            IDLE:    if (launch) stateNext = REQ;
            REQ:     if (mem_ack) stateNext = RESP;
            RESP:    stateNext = IDLE;
            default: stateNext = IDLE;
        endcase
    end

    always_comb begin
        mem_req = (state == REQ);
        stall   = !rst && (launch || (state == REQ));
    end

    // Bus-side registers: captured once at launch so they stay constant through REQ.
    // Low address bits are forced to 00; with the alignment check on, only aligned
    // addresses ever launch, so this is a no-op there.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_addr  <= '0;
            mem_wdata <= '0;
            mem_we    <= 1'b0;
            destReg   <= REG_ZERO;
        end else if (launch) begin
            mem_addr  <= {ALUResult[WORD_W-1:2], 2'b00};
            mem_wdata <= RtData;
            mem_we    <= Write;
            destReg   <= ALUResultRegAddr;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wb_valid <= 1'b0;
            wb_addr  <= REG_ZERO;
            wb_data  <= '0;
        end else begin
            wb_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (!memOp) begin
                        wb_data  <= ALUResult;
                        wb_addr  <= ALUResultRegAddr;
                        wb_valid <= (ALUResultRegAddr != REG_ZERO);
                    end
                end
                REQ: begin
                    if (mem_ack && !mem_we) begin
                        wb_data  <= mem_rdata;
                        wb_addr  <= destReg;
                        wb_valid <= (destReg != REG_ZERO);
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef MEM_ALIGN_CHECK_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) excp <= 1'b0;
        else     excp <= (state == IDLE) && misaligned;
    end
`else
    assign excp = 1'b0;
`endif

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage: ALU writeback, loads/stores with wait states,
// misaligned access, reset during a request and Read+Write priority.
module tb_mem_stage;
    import mips_pkg::*;

    logic              clk = 1'b0;
    logic              rst;
    logic              Read, Write;
    logic [WORD_W-1:0] ALUResult, RtData, mem_rdata;
    logic [REG_AW-1:0] ALUResultRegAddr;
    logic              mem_req, mem_we, mem_ack, stall, wb_valid, excp;
    logic [WORD_W-1:0] mem_addr, mem_wdata, wb_data;
    logic [REG_AW-1:0] wb_addr;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mem_stage dut (
        .clk              (clk),
        .rst              (rst),
        .Read             (Read),
        .Write            (Write),
        .ALUResult        (ALUResult),
        .ALUResultRegAddr (ALUResultRegAddr),
        .RtData           (RtData),
        .mem_req          (mem_req),
        .mem_we           (mem_we),
        .mem_addr         (mem_addr),
        .mem_wdata        (mem_wdata),
        .mem_ack          (mem_ack),
        .mem_rdata        (mem_rdata),
        .stall            (stall),
        .wb_valid         (wb_valid),
        .wb_addr          (wb_addr),
        .wb_data          (wb_data),
        .excp             (excp)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $display("FAIL %s: observed %h expected %h", tag, obs, exp);
            $error("check %s", tag);
        end
    endtask

    // Advance one clock; inputs are then driven and outputs sampled 1ns after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; Read = 1'b0; Write = 1'b0; ALUResult = '0; RtData = '0;
        ALUResultRegAddr = '0; mem_ack = 1'b0; mem_rdata = '0;
        step(); step();
        chk("rst_req",    {31'd0, mem_req},  32'd0);
        chk("rst_stall",  {31'd0, stall},    32'd0);
        chk("rst_wbv",    {31'd0, wb_valid}, 32'd0);
        chk("rst_wbdata", wb_data,           32'd0);
        chk("rst_addr",   mem_addr,          32'd0);
        chk("rst_excp",   {31'd0, excp},     32'd0);
        rst = 1'b0;
        step();

        // Non-memory writeback
        ALUResult = 32'h1234_5678; ALUResultRegAddr = 5'd8;
        #1 chk("alu_stall", {31'd0, stall}, 32'd0);
        step();
        chk("alu_wbv",  {31'd0, wb_valid}, 32'd1);
        chk("alu_wba",  {27'd0, wb_addr},  32'd8);
        chk("alu_wbd",  wb_data,           32'h1234_5678);

        // Load, zero wait
        Read = 1'b1; ALUResult = 32'h100; ALUResultRegAddr = 5'd9;
        #1 chk("lw_stall0", {31'd0, stall}, 32'd1);
        chk("lw_req0",   {31'd0, mem_req}, 32'd0);
        step();
        chk("lw_req1",   {31'd0, mem_req}, 32'd1);
        chk("lw_we",     {31'd0, mem_we},  32'd0);
        chk("lw_addr",   mem_addr,         32'h100);
        chk("lw_stall1", {31'd0, stall},   32'd1);
        chk("lw_wbv_req", {31'd0, wb_valid}, 32'd0);
        mem_ack = 1'b1; mem_rdata = 32'hDEAD_BEEF;
        step();
        mem_ack = 1'b0;
        chk("lw_req_resp",   {31'd0, mem_req},  32'd0);
        chk("lw_stall_resp", {31'd0, stall},    32'd0);
        chk("lw_wbv",        {31'd0, wb_valid}, 32'd1);
        chk("lw_wbd",        wb_data,           32'hDEAD_BEEF);
        chk("lw_wba",        {27'd0, wb_addr},  32'd9);
        Read = 1'b0; ALUResult = 32'h0; ALUResultRegAddr = 5'd0;
        step();
        chk("lw_idle_wbv", {31'd0, wb_valid}, 32'd0);
        chk("lw_idle_req", {31'd0, mem_req},  32'd0);

        // Store with 4 REQ cycles
        Write = 1'b1; ALUResult = 32'h200; RtData = 32'hCAFE_F00D; ALUResultRegAddr = 5'd3;
        #1 chk("sw_stall0", {31'd0, stall}, 32'd1);
        step();
        for (int i = 0; i < 4; i++) begin
            chk("sw_req",   {31'd0, mem_req},  32'd1);
            chk("sw_we",    {31'd0, mem_we},   32'd1);
            chk("sw_addr",  mem_addr,          32'h200);
            chk("sw_wdata", mem_wdata,         32'hCAFE_F00D);
            chk("sw_stall", {31'd0, stall},    32'd1);
            chk("sw_wbv",   {31'd0, wb_valid}, 32'd0);
            if (i == 3) mem_ack = 1'b1;
            step();
        end
        mem_ack = 1'b0;
        chk("sw_resp_req",   {31'd0, mem_req},  32'd0);
        chk("sw_resp_stall", {31'd0, stall},    32'd0);
        chk("sw_resp_wbv",   {31'd0, wb_valid}, 32'd0);
        Write = 1'b0; ALUResult = 32'h0; ALUResultRegAddr = 5'd0;
        step();
        chk("sw_idle_wbv", {31'd0, wb_valid}, 32'd0);

        // Misaligned load at 0x102
        Read = 1'b1; ALUResult = 32'h102; ALUResultRegAddr = 5'd5;
`ifdef MEM_ALIGN_CHECK_EN
        #1 chk("mis_stall", {31'd0, stall}, 32'd0);
        step();
        Read = 1'b0; ALUResult = 32'h0; ALUResultRegAddr = 5'd0;
        chk("mis_excp", {31'd0, excp},     32'd1);
        chk("mis_req",  {31'd0, mem_req},  32'd0);
        chk("mis_wbv",  {31'd0, wb_valid}, 32'd0);
        step();
        chk("mis_excp_end", {31'd0, excp}, 32'd0);
        chk("mis_req_end",  {31'd0, mem_req}, 32'd0);
`else
        #1 chk("mis_stall", {31'd0, stall}, 32'd1);
        step();
        chk("mis_addr", mem_addr,        32'h100);
        chk("mis_req",  {31'd0, mem_req}, 32'd1);
        chk("mis_excp", {31'd0, excp},    32'd0);
        mem_ack = 1'b1; mem_rdata = 32'h0BAD_F00D;
        step();
        mem_ack = 1'b0;
        chk("mis_wbd", wb_data, 32'h0BAD_F00D);
        Read = 1'b0; ALUResult = 32'h0; ALUResultRegAddr = 5'd0;
        step();
`endif

        // Reset in the middle of a request
        Read = 1'b1; ALUResult = 32'h300; ALUResultRegAddr = 5'd4;
        step();
        chk("rr_req_pre", {31'd0, mem_req}, 32'd1);
        rst = 1'b1;
        #1;
        chk("rr_req",   {31'd0, mem_req},  32'd0);
        chk("rr_stall", {31'd0, stall},    32'd0);
        chk("rr_wbv",   {31'd0, wb_valid}, 32'd0);
        chk("rr_addr",  mem_addr,          32'd0);
        Read = 1'b0; ALUResult = 32'h0; ALUResultRegAddr = 5'd0;
        #2 rst = 1'b0;
        step();
        mem_ack = 1'b1; mem_rdata = 32'h7777_7777;
        step();
        mem_ack = 1'b0;
        chk("late_ack_req", {31'd0, mem_req},  32'd0);
        chk("late_ack_wbv", {31'd0, wb_valid}, 32'd0);
        chk("late_ack_wbd", wb_data,           32'd0);
        Read = 1'b1; ALUResult = 32'h40; ALUResultRegAddr = 5'd10;
        step();
        chk("rr2_req",  {31'd0, mem_req}, 32'd1);
        chk("rr2_addr", mem_addr,         32'h40);
        mem_ack = 1'b1; mem_rdata = 32'h55AA_33CC;
        step();
        mem_ack = 1'b0;
        chk("rr2_wbv", {31'd0, wb_valid}, 32'd1);
        chk("rr2_wbd", wb_data,           32'h55AA_33CC);
        chk("rr2_wba", {27'd0, wb_addr},  32'd10);
        Read = 1'b0; ALUResult = 32'h0; ALUResultRegAddr = 5'd0;
        step();

        // Read and Write both high: behaves as a store
        Read = 1'b1; Write = 1'b1; ALUResult = 32'h10; RtData = 32'h0000_0001;
        ALUResultRegAddr = 5'd7;
        step();
        chk("rw_we",    {31'd0, mem_we}, 32'd1);
        chk("rw_wdata", mem_wdata,       32'h1);
        mem_ack = 1'b1; mem_rdata = 32'hFFFF_0000;
        step();
        mem_ack = 1'b0;
        chk("rw_wbv", {31'd0, wb_valid}, 32'd0);
        Read = 1'b0; Write = 1'b0; ALUResult = 32'h0000_FFFF; ALUResultRegAddr = 5'd0;
        step();
        step();
        chk("r0_wbv", {31'd0, wb_valid}, 32'd0);
        chk("r0_wbd", wb_data,           32'h0000_FFFF);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mem_stage.md
# mem_stage

Load/store memory stage between the ALU and the data-memory bus. It consumes the ALU's `Read`/`Write` strobes, effective address (`ALUResult`) and store data (`RtData`), and runs a req/ack word transaction on the memory bus. It stalls the upstream pipeline while the transaction is outstanding and presents a registered writeback (data + register address) to the register file.

## Interface
- Parameters: none; widths are fixed by the shared package.
- `clk`  in  1  single clock; all state changes on rising edge.
- `rst`  in  1  reset, asynchronous, active-high.
- `Read`  in  1  LW in flight (from ALU).
- `Write`  in  1  SW in flight (from ALU).
- `ALUResult`  in  32  effective address for LW/SW, otherwise the result to write back.
- `ALUResultRegAddr`  in  5  destination register; 0 means no write.
- `RtData`  in  32  store data.
- `mem_req`  out  1  bus request, held until `mem_ack`.
- `mem_we`  out  1  1 = write, 0 = read; valid while `mem_req`.
- `mem_addr`  out  32  word address, registered.
- `mem_wdata`  out  32  store data, registered.
- `mem_ack`  in  1  one-cycle completion strobe from memory.
- `mem_rdata`  in  32  read data, valid with `mem_ack`.
- `stall`  out  1  upstream must hold its inputs stable.
- `wb_valid`  out  1  register write enable, one cycle per instruction.
- `wb_addr`  out  5  register write address.
- `wb_data`  out  32  register write data.
- `excp`  out  1  one-cycle misaligned-access pulse.

## Operation
- FSM states: IDLE, REQ, RESP.
- **IDLE, non-memory instruction** (`Read`=`Write`=0):
  - next edge: `wb_data`<=`ALUResult`, `wb_addr`<=`ALUResultRegAddr`.
  - `wb_valid`<=(`ALUResultRegAddr`!=0).
  - Stay in IDLE.
- **IDLE, `Read|Write`, aligned:**
  - `stall`=1 combinationally.
  - Next edge: latch `mem_addr`, `mem_wdata`, `mem_we`=`Write`, and the destination; set `wb_valid`<=0; go to REQ.
- **REQ:**
  - `mem_req`=1, `stall`=1; address and data stay constant.
  - On `mem_ack`:
    - LW: `wb_data`<=`mem_rdata`, `wb_addr`<=latched destination, `wb_valid`<=(dest!=0).
    - SW: `wb_valid`<=0.
    - Go to RESP.
- **RESP:**
  - `mem_req`=0, `stall`=0; the upstream advances at this edge.
  - Inputs are ignored, so the still-presented LW/SW is not relaunched.
  - Next edge: `wb_valid`<=0; go to IDLE.
- `Read` and `Write` both high: treat as a write.
- `mem_ack` outside REQ: ignored.
- Reset:
  - All registered outputs are 0 and the state is IDLE.
  - `stall` is forced 0 while `rst`=1.
  - Reset mid-REQ drops `mem_req` immediately; the memory must tolerate an abandoned request.

## Timing
- Non-memory instruction: writeback 1 cycle after presentation; no stall.
- LW/SW with ack after k≥1 REQ cycles: occupies 1+k+1 cycles.
  - `stall` is high for 1+k cycles.
  - LW `wb_valid` is high during RESP.
- Minimum back-to-back LW throughput: one every 3 cycles.
- `mem_req` rises 1 cycle after the instruction is presented and falls the cycle after `mem_ack`.

## Configuration
- `MEM_ALIGN_CHECK_EN` defined:
  - In IDLE, `Read|Write` with `ALUResult[1:0]`!=0 raises no stall and no bus transaction.
  - Next edge: `excp`<=1 for one cycle and `wb_valid`<=0.
- `MEM_ALIGN_CHECK_EN` undefined:
  - `mem_addr[1:0]` is forced to 00.
  - `excp` is tied 0.
  - Every LW/SW runs a transaction.

## Structure
- Shared package `mips_pkg`: state enum (IDLE/REQ/RESP), `WORD_W`=32, `REG_AW`=5, `REG_ZERO`=5'd0.
- One small sub-module `mem_align_chk`: combinational; inputs address and `Read|Write`, output misaligned flag. Compiled to constant 0 without the macro.
- The FSM and writeback registers stay in `mem_stage`.

## Test plan
- **Non-memory write-back:** ALU op with `ALUResult`=0x12345678, dest 8 → next cycle `wb_valid`=1, `wb_addr`=8, `wb_data`=0x12345678, `stall`=0.
- **Load, zero wait:** LW at 0x100, `mem_ack` in first REQ cycle with `mem_rdata`=0xDEADBEEF, dest 9 → `mem_req`=1 for 1 cycle, `mem_we`=0, `stall` 2 cycles, then `wb_valid`=1 / `wb_data`=0xDEADBEEF / `wb_addr`=9 in RESP.
- **Store, wait states:** SW at 0x200, `RtData`=0xCAFEF00D, ack after 4 cycles → `mem_addr`/`mem_wdata` constant for 4 cycles, `mem_we`=1, `stall` 5 cycles, `wb_valid` never 1.
- **Misaligned LW at 0x102:**
  - With `MEM_ALIGN_CHECK_EN`: `excp` pulses 1 cycle, `mem_req` stays 0, no stall.
  - Without: `mem_addr`=0x100.
- **Reset mid-REQ:** assert `rst` during REQ → `mem_req`, `stall`, `wb_valid` drop to 0 the same cycle. After release, a late `mem_ack` is ignored and the next LW runs normally.
- **Read and Write both high, then `ALUResultRegAddr`=0:** both-high runs as a write (`mem_we`=1). A non-memory op with dest 0 gives `wb_valid`=0.
